// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer: ping-pong capture of NCH ADC channels into two M_SAMPLES-deep banks.
// Optional macro STATUS_CAPTURE_EN adds frame_status, the per-channel OR of stripped status bits.
module adc_frame_buffer #(
  parameter  int N_ADC      = 2,
  parameter  int CH_PER_ADC = 4,
  parameter  int WORD_W     = 32,
  parameter  int STATUS_W   = 10,
  parameter  int M_SAMPLES  = 512,
  localparam int NCH        = N_ADC * CH_PER_ADC,
  localparam int DATA_W     = WORD_W - STATUS_W,
  localparam int IDX_W      = $clog2(M_SAMPLES),
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_valid,
  input  logic [NCH*WORD_W-1:0]    adc_words,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     frame_ready,
  output logic                     frame_avail,
  input  logic                     frame_release,
  output logic                     overflow,
  output logic [15:0]              frame_count
`ifdef STATUS_CAPTURE_EN
  , output logic [NCH*STATUS_W-1:0] frame_status
`endif
);

  typedef enum logic [1:0] {FREE = 2'd0, FILL = 2'd1, HELD = 2'd2} bank_st_e;

  bank_st_e                 bank_q [2];
  bank_st_e                 bank_d [2];
  logic                     wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic                     ready_q, ready_d, avail_q, avail_d, ovf_q, ovf_d;
  logic [15:0]              count_q, count_d;
  logic                     wr_en_s, wr_fresh_s, rel_s;
  logic [NCH*STATUS_W-1:0]  stat_s;
  logic signed [DATA_W-1:0] rd_data_q;
  logic signed [DATA_W-1:0] mem_q [2][NCH][M_SAMPLES];

  assign rel_s = frame_release && avail_q;

  // Status fields of the incoming words, one STATUS_W slice per channel.
  always_comb begin
    stat_s = '0;
    for (int c = 0; c < NCH; c++) begin
      stat_s[c*STATUS_W +: STATUS_W] = adc_words[c*WORD_W +: STATUS_W];
    end
  end

  // Bank state machine: release is applied before the incoming sample is judged.
  always_comb begin
    bank_d     = bank_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_idx_d   = wr_idx_q;
    ready_d    = 1'b0;
    ovf_d      = ovf_q;
    count_d    = count_q;
    wr_en_s    = 1'b0;
    wr_fresh_s = 1'b0;
    if (rel_s) begin
      bank_d[rd_bank_q] = FREE;
      if (bank_q[~rd_bank_q] == HELD) begin
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_bank_d = rd_bank_q;
      end
    end else begin
      rd_bank_d = rd_bank_q;
    end
    if (sample_valid) begin
      if (bank_d[wr_bank_q] != HELD) begin
        wr_en_s    = 1'b1;
        wr_fresh_s = (bank_d[wr_bank_q] == FREE);
        if (wr_idx_q == IDX_W'(M_SAMPLES - 1)) begin
          bank_d[wr_bank_q] = HELD;
          wr_idx_d          = '0;
          wr_bank_d         = ~wr_bank_q;
          ready_d           = 1'b1;
          count_d           = count_q + 16'd1;
          // An older frame still held keeps priority on the read port.
          if (bank_d[~wr_bank_q] != HELD) begin
            rd_bank_d = wr_bank_q;
          end else begin
            rd_bank_d = rd_bank_d;
          end
        end else begin
          bank_d[wr_bank_q] = FILL;
          wr_idx_d          = wr_idx_q + IDX_W'(1);
        end
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      ovf_d = ovf_q;
    end
    avail_d = (bank_d[0] == HELD) || (bank_d[1] == HELD);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q[0] <= FREE;
      bank_q[1] <= FREE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      ready_q   <= 1'b0;
      avail_q   <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      bank_q    <= bank_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      ready_q   <= ready_d;
      avail_q   <= avail_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

  // Sample memory: all channels written in parallel, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        mem_q[wr_bank_q][c][wr_idx_q] <= adc_words[c*WORD_W+STATUS_W +: DATA_W];
      end
    end
  end

  generate
    if (NCH == (1 << CH_W)) begin : g_rd_full
      // Registered read; every rd_ch code maps to a real channel.
      always_ff @(posedge clk) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= mem_q[rd_bank_q][rd_ch][rd_idx];
      end
    end else begin : g_rd_range
      // Registered read; channel codes past NCH return zero.
      always_ff @(posedge clk) begin
        if (!rst_n)                   rd_data_q <= '0;
        else if (int'(rd_ch) >= NCH)  rd_data_q <= '0;
        else                          rd_data_q <= mem_q[rd_bank_q][rd_ch][rd_idx];
      end
    end
  endgenerate

`ifdef STATUS_CAPTURE_EN
  logic [NCH*STATUS_W-1:0] acc_q [2];
  logic [NCH*STATUS_W-1:0] acc_d [2];
  logic [NCH*STATUS_W-1:0] fs_q, fs_d;

  // Per-bank status OR; restarts when a free bank takes its first sample.
  always_comb begin
    acc_d = acc_q;
    fs_d  = fs_q;
    if (wr_en_s) begin
      acc_d[wr_bank_q] = wr_fresh_s ? stat_s : (acc_q[wr_bank_q] | stat_s);
    end else begin
      acc_d[wr_bank_q] = acc_q[wr_bank_q];
    end
    if (avail_d && (!avail_q || (rd_bank_d != rd_bank_q))) begin
      fs_d = acc_d[rd_bank_d];
    end else begin
      fs_d = fs_q;
    end
  end

  // Status accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q[0] <= '0;
      acc_q[1] <= '0;
      fs_q     <= '0;
    end else begin
      acc_q <= acc_d;
      fs_q  <= fs_d;
    end
  end

  assign frame_status = fs_q;
`else
  logic unused_status_s;
  assign unused_status_s = ^{stat_s, wr_fresh_s};
`endif

  assign rd_data     = rd_data_q;
  assign frame_ready = ready_q;
  assign frame_avail = avail_q;
  assign overflow    = ovf_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Directed bench for adc_frame_buffer (default build, status capture disabled).
module tb_adc_frame_buffer;
  localparam int NCH    = 8;
  localparam int WORD_W = 32;
  localparam int DATA_W = 22;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  sample_valid = 1'b0;
  logic                  frame_release = 1'b0;
  logic [NCH*WORD_W-1:0] adc_words = '0;
  logic [2:0]            rd_ch = 3'd0;
  logic [8:0]            rd_idx = 9'd0;
  logic [DATA_W-1:0]     rd_data;
  logic                  frame_ready, frame_avail, overflow;
  logic [15:0]           frame_count;

  int n_checks  = 0;
  int n_pass    = 0;
  int ready_cnt = 0;

  adc_frame_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid  (sample_valid),
    .adc_words     (adc_words),
    .rd_ch         (rd_ch),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .frame_ready   (frame_ready),
    .frame_avail   (frame_avail),
    .frame_release (frame_release),
    .overflow      (overflow),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  // Pulse counter; registered outputs are stable when read at the rising edge.
  always @(posedge clk) if (frame_ready) ready_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [NCH*WORD_W-1:0] pat(input int base, input int n);
    logic [NCH*WORD_W-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*WORD_W +: WORD_W] = (32'(c*1000 + n + base) << 10) | 32'h3FF;
    return w;
  endfunction

  // One clock of stimulus, entered and left on a falling edge.
  task automatic cyc(input logic v, input logic rel, input logic [NCH*WORD_W-1:0] w);
    sample_valid  = v;
    frame_release = rel;
    adc_words     = w;
    @(negedge clk);
    sample_valid  = 1'b0;
    frame_release = 1'b0;
  endtask

  task automatic rd(input int ch, input int idx, output logic [DATA_W-1:0] d);
    rd_ch  = 3'(ch);
    rd_idx = 9'(idx);
    @(negedge clk);
    d = rd_data;
  endtask

  initial begin
    logic [DATA_W-1:0]     d;
    logic [NCH*WORD_W-1:0] w;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, frame_ready}, 32'd0);
    chk("rst_avail", {31'd0, frame_avail}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow},    32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);
    chk("rst_rdata", {10'd0, rd_data},     32'd0);
    rst_n = 1'b1;

    // Frame 1 -> bank 0
    for (int n = 0; n < 511; n++) cyc(1'b1, 1'b0, pat(0, n));
    chk("f1_avail_pre", {31'd0, frame_avail}, 32'd0);
    cyc(1'b1, 1'b0, pat(0, 511));
    chk("f1_ready", {31'd0, frame_ready}, 32'd1);
    chk("f1_avail", {31'd0, frame_avail}, 32'd1);
    chk("f1_count", {16'd0, frame_count}, 32'd1);
    chk("f1_ovf",   {31'd0, overflow},    32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("f1_ready_drop", {31'd0, frame_ready}, 32'd0);
    rd(3, 5, d);
    chk("f1_ch3_i5", {10'd0, d}, 32'd3005);
    rd(7, 511, d);
    chk("f1_ch7_i511", {10'd0, d}, 32'd7511);
    chk("f1_ready_cnt", 32'(ready_cnt), 32'd1);

    // Frame 2 -> bank 1, first sample carries sign-extremes
    w = pat(100, 0);
    w[7*WORD_W +: WORD_W] = 32'hFFFFFC00;
    w[6*WORD_W +: WORD_W] = 32'h80000000;
    cyc(1'b1, 1'b0, w);
    for (int n = 1; n < 512; n++) cyc(1'b1, 1'b0, pat(100, n));
    chk("f2_count", {16'd0, frame_count}, 32'd2);
    chk("f2_avail", {31'd0, frame_avail}, 32'd1);
    rd(3, 5, d);
    chk("f2_oldest_read", {10'd0, d}, 32'd3005);
    chk("f2_ready_cnt", 32'(ready_cnt), 32'd2);

    // Both banks held: strobe is dropped
    cyc(1'b1, 1'b0, pat(900, 0));
    chk("ovf_set",   {31'd0, overflow},    32'd1);
    chk("ovf_count", {16'd0, frame_count}, 32'd2);

    // Release bank 0; bank 1 becomes readable
    cyc(1'b0, 1'b1, '0);
    chk("rel1_avail", {31'd0, frame_avail}, 32'd1);
    rd(7, 0, d);
    chk("neg_one", {10'd0, d}, 32'h003FFFFF);
    rd(6, 0, d);
    chk("most_neg", {10'd0, d}, 32'h00200000);
    rd(0, 0, d);
    chk("f2_ch0_i0", {10'd0, d}, 32'd100);
    rd(2, 511, d);
    chk("f2_ch2_i511", {10'd0, d}, 32'd2611);

    // Frame 3 -> freed bank 0, last strobe coincides with release of bank 1
    for (int n = 0; n < 511; n++) cyc(1'b1, 1'b0, pat(200, n));
    chk("f3_avail_pre", {31'd0, frame_avail}, 32'd1);
    cyc(1'b1, 1'b1, pat(200, 511));
    chk("f3_ready", {31'd0, frame_ready}, 32'd1);
    chk("f3_avail", {31'd0, frame_avail}, 32'd1);
    chk("f3_count", {16'd0, frame_count}, 32'd3);
    rd(0, 0, d);
    chk("f3_ch0_i0", {10'd0, d}, 32'd200);
    rd(5, 511, d);
    chk("f3_ch5_i511", {10'd0, d}, 32'd5711);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    cyc(1'b0, 1'b1, '0);
    chk("rel3_avail", {31'd0, frame_avail}, 32'd0);
    cyc(1'b0, 1'b1, '0);
    chk("rel_idle_avail", {31'd0, frame_avail}, 32'd0);
    chk("rel_idle_count", {16'd0, frame_count}, 32'd3);

    // Reset in the middle of a frame
    for (int n = 0; n < 200; n++) cyc(1'b1, 1'b0, pat(300, n));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_ready", {31'd0, frame_ready}, 32'd0);
    chk("mrst_avail", {31'd0, frame_avail}, 32'd0);
    chk("mrst_ovf",   {31'd0, overflow},    32'd0);
    chk("mrst_count", {16'd0, frame_count}, 32'd0);
    chk("mrst_rdata", {10'd0, rd_data},     32'd0);
    ready_cnt = 0;
    for (int n = 0; n < 511; n++) cyc(1'b1, 1'b0, pat(400, n));
    chk("f4_avail_pre", {31'd0, frame_avail}, 32'd0);
    chk("f4_no_pulse",  32'(ready_cnt),        32'd0);
    cyc(1'b1, 1'b0, pat(400, 511));
    chk("f4_ready", {31'd0, frame_ready}, 32'd1);
    chk("f4_count", {16'd0, frame_count}, 32'd1);
    rd(1, 0, d);
    chk("f4_ch1_i0", {10'd0, d}, 32'd1400);
    rd(1, 511, d);
    chk("f4_ch1_i511", {10'd0, d}, 32'd1911);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adc_frame_buffer.md
Name: adc_frame_buffer

Overview:
- Parametrised ping-pong frame buffer for the ADC front end.
- Captures one word per channel from N_ADC converters each time a sample strobe arrives, strips the status bits and stores signed samples.
- Each frame is an (N_ADC*CH_PER_ADC) x M_SAMPLES matrix.
- The downstream consumer reads a completed frame through a random-access port while the other bank fills, and releases the frame with a handshake.

Parameters:
- N_ADC, 2, number of ADC devices.
- CH_PER_ADC, 4, channels per ADC.
- WORD_W, 32, raw ADC word width.
- STATUS_W, 10, low-order status bits stripped from each word.
- M_SAMPLES, 512, samples per frame; power of two, >=2.
- (derived) NCH = N_ADC*CH_PER_ADC; DATA_W = WORD_W-STATUS_W; IDX_W = clog2(M_SAMPLES); CH_W = clog2(NCH) (min 1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- sample_valid  in  1  one-cycle strobe, already synchronised to clk (derived from CASCOUT); adc_words valid in the same cycle.
- adc_words  in  NCH*WORD_W  raw words; channel c occupies bits [c*WORD_W +: WORD_W]; ADC k owns channels k*CH_PER_ADC..+CH_PER_ADC-1.
- rd_ch  in  CH_W  read channel.
- rd_idx  in  IDX_W  read sample index.
- rd_data  out  DATA_W  signed sample from the ready bank; 1-cycle latency.
- frame_ready  out  1  one-cycle pulse when a bank completes.
- frame_avail  out  1  level; a completed bank is held for reading.
- frame_release  in  1  one-cycle pulse; consumer done with the held bank.
- overflow  out  1  sticky; a sample was dropped because both banks were occupied.
- frame_count  out  16  completed frames; wraps at 2^16.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Both banks FREE; wr_bank=0; wr_idx=0.
  - rd_data=0, frame_ready=0, frame_avail=0, overflow=0, frame_count=0.
  - Reset mid-frame discards the partial frame and any held frame; memory contents are not cleared.
- Sample conversion:
  - sample = word[WORD_W-1:STATUS_W] taken as signed (arithmetic shift right by STATUS_W).
  - Stored exactly; no rounding.
- Storage order:
  - The first sample of a frame goes to index 0, ascending to M_SAMPLES-1.
  - Channel c goes to row c.
- Bank states: FREE, FILL, HELD.
- On sample_valid, if wr_bank is FREE or FILL:
  - Write all NCH channels at wr_idx in one cycle; the bank becomes FILL.
  - If wr_idx == M_SAMPLES-1:
    - wr_idx := 0; the bank goes to HELD.
    - rd_bank := wr_bank; wr_bank toggles.
    - frame_ready pulses the following cycle; frame_avail rises the same cycle as the pulse.
    - frame_count increments.
  - Otherwise wr_idx increments.
- On sample_valid, if wr_bank is HELD (the consumer has not released it yet):
  - Sample dropped; overflow := 1 next cycle; wr_idx unchanged.
- frame_release:
  - When frame_avail=1, the oldest HELD bank goes FREE.
  - frame_avail stays 1 if the other bank is also HELD (rd_bank switches to it); otherwise it falls the next cycle.
  - frame_release while frame_avail=0 is ignored.
- Simultaneous release and frame completion in the same cycle:
  - The release applies to the previously held bank first.
  - The newly completed bank then becomes rd_bank; frame_avail stays 1.
- Simultaneous release and sample_valid when wr_bank is HELD: release takes effect first and the sample is written (no drop).
- Read port:
  - rd_data registered from mem[rd_bank][rd_ch][rd_idx]; valid one cycle after the address.
  - rd_data is undefined while frame_avail=0.
  - rd_ch >= NCH returns 0.
- Max sample rate: one sample_valid per clk cycle.

Optional Feature:
- STATUS_CAPTURE_EN
- Defined:
  - Adds output frame_status [NCH*STATUS_W-1:0], the per-channel bitwise OR of status fields over all samples of the frame now in rd_bank.
  - Updated on the same cycle frame_avail rises or rd_bank switches.
  - Per-bank accumulators clear when a bank enters FILL from FREE; reset value 0.
- Undefined: port absent; status bits discarded.

Test Plan:
- Reset, then 512 strobes where ch c word = ((c*1000+n)<<10) | 10'h3FF -> frame_ready pulses once; rd(ch3, idx 5) = 3005; frame_count=1; overflow=0.
- Word 32'hFFFFFC00 on ch7 -> rd_data = -1 (22'h3FFFFF); word 32'h80000000 -> -2097152.
- Fill two frames with no release, then send a 1025th strobe -> overflow=1; sample dropped; after frame_release the next strobe writes idx 0 of the freed bank.
- frame_release pulsed in the same cycle as the 512th strobe of frame 2 -> frame_avail stays 1; rd_bank = bank 1; rd(ch0, idx 0) = frame-2 data.
- rst_n low at sample 200 for 1 cycle -> all outputs 0; the next frame_ready arrives exactly 512 strobes later.
- STATUS_CAPTURE_EN defined, one sample on ch2 with status 10'h004 -> frame_status slice 2 = 10'h004, other slices 0; slice 2 cleared in the next frame.
